operand_pair_serializer: RTL

Parallel-to-serial front end for the bit-serial comparator path. Latches two WIDTH-bit operands on a load handshake and streams them out one bit pair per clock, MSB-first or LSB-first, with valid/last framing and a completion pulse. Sits between the operand source (register file or test stimulus) and the serial-mode comparator's operand inputs.

---
 rtl/operand_pair_serializer_pkg.sv | 20 ++
 rtl/operand_pair_serializer_piso.sv | 56 +++++
 rtl/operand_pair_serializer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/operand_pair_serializer_pkg.sv
// Shared definitions for the operand serializer and the serial comparator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package operand_pair_serializer_pkg;

    // Transfer sequencing states, shared with the serial comparator
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } ser_state_e;

    // Shift-order encoding carried on msb_first
    localparam logic ORDER_MSB_FIRST = 1'b1;
    localparam logic ORDER_LSB_FIRST = 1'b0;

    // Default operand width used by the comparator path
    localparam int DEFAULT_WIDTH = 32;

endpackage : operand_pair_serializer_pkg

// File: rtl/operand_pair_serializer_piso.sv
// Parallel-in serial-out shift register with a direction latched at load time.
// Latency: ser_out reflects the bit after the one the parent presents first.
// Backpressure: none; shifts only when the parent asserts shift.
module piso_shift_reg
    import operand_pair_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             msb_first,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;

    // Load stores the operand already advanced by one position, because the
    // parent registers the first bit itself on the load edge; ser_out then
    // always holds the pair that goes out on the next edge.
    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        if (load) begin
            dir_d = msb_first;
            if (msb_first == ORDER_MSB_FIRST) begin
                data_d = {par_in[WIDTH-2:0], 1'b0};
            end else begin
                data_d = {1'b0, par_in[WIDTH-1:1]};
            end
        end else if (shift) begin
            if (dir_q == ORDER_MSB_FIRST) begin
                data_d = {data_q[WIDTH-2:0], 1'b0};
            end else begin
                data_d = {1'b0, data_q[WIDTH-1:1]};
            end
        end
    end

    // Operand and direction storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            dir_q  <= ORDER_LSB_FIRST;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
        end
    end

    assign ser_out = (dir_q == ORDER_MSB_FIRST) ? data_q[WIDTH-1] : data_q[0];

endmodule : piso_shift_reg

// File: rtl/operand_pair_serializer.sv
// Latches two operands and streams them one bit pair per clock with first/last framing.
// Latency: first pair one cycle after load; done one cycle after the last pair.
// Backpressure: load accepted only while ready; abort cancels an active transfer.
module operand_pair_serializer
    import operand_pair_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             msb_first,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             a_bit,
    output logic             b_bit,
    output logic             bit_valid,
    output logic             bit_first,
    output logic             bit_last,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PRE_LAST = CW'(WIDTH - 2);

    ser_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          a_bit_q, a_bit_d;
    logic          b_bit_q, b_bit_d;
    logic          bit_valid_q, bit_valid_d;
    logic          bit_first_q, bit_first_d;
    logic          bit_last_q, bit_last_d;
    logic          done_q, done_d;

    logic          sr_load;
    logic          sr_shift;
    logic          a_ser;
    logic          b_ser;

    piso_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
        .clk       (clk),
        .rst       (rst),
        .load      (sr_load),
        .shift     (sr_shift),
        .msb_first (msb_first),
        .par_in    (a),
        .ser_out   (a_ser)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
        .clk       (clk),
        .rst       (rst),
        .load      (sr_load),
        .shift     (sr_shift),
        .msb_first (msb_first),
        .par_in    (b),
        .ser_out   (b_ser)
    );

    // Next-state and next-output logic; every output is computed here and
    // registered below so nothing reaches the ports combinationally.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = 1'b0;
        a_bit_d     = 1'b0;
        b_bit_d     = 1'b0;
        bit_valid_d = 1'b0;
        bit_first_d = 1'b0;
        bit_last_d  = 1'b0;
        done_d      = 1'b0;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                // abort has priority over a simultaneous load
                if (load && !abort) begin
                    state_d     = ST_SHIFT;
                    cnt_d       = '0;
                    ready_d     = 1'b0;
                    sr_load     = 1'b1;
                    bit_valid_d = 1'b1;
                    bit_first_d = 1'b1;
                    bit_last_d  = (CNT_LAST == '0);
                    a_bit_d     = (msb_first == ORDER_MSB_FIRST) ? a[WIDTH-1] : a[0];
                    b_bit_d     = (msb_first == ORDER_MSB_FIRST) ? b[WIDTH-1] : b[0];
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    // Cancel silently: no last, no done, straight back to idle
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d       = cnt_q + CW'(1);
                    sr_shift    = 1'b1;
                    bit_valid_d = 1'b1;
                    bit_last_d  = (cnt_q == CNT_PRE_LAST);
                    a_bit_d     = a_ser;
                    b_bit_d     = b_ser;
                end
            end

            ST_DONE: begin
                // abort is ignored here; the done pulse is already committed
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ready_d = 1'b1;
            end
        endcase
    end

    // FSM state, bit counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            a_bit_q     <= 1'b0;
            b_bit_q     <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_first_q <= 1'b0;
            bit_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            a_bit_q     <= a_bit_d;
            b_bit_q     <= b_bit_d;
            bit_valid_q <= bit_valid_d;
            bit_first_q <= bit_first_d;
            bit_last_q  <= bit_last_d;
            done_q      <= done_d;
        end
    end

    assign ready     = ready_q;
    assign a_bit     = a_bit_q;
    assign b_bit     = b_bit_q;
    assign bit_valid = bit_valid_q;
    assign bit_first = bit_first_q;
    assign bit_last  = bit_last_q;
    assign done      = done_q;

endmodule : operand_pair_serializer
